// File: rtl/seg7_pkg.sv
// Shared definitions for the seg7 scan controller.
//   PWM_PHASES / BRIGHT_W / PHASE_W : brightness PWM geometry (16 phases, 4-bit level)
//   cnt_width()   : counter width for a 0..n-1 counter, never narrower than 1 bit
//   drive_level() : maps a logical "active" bit onto a pin level for a given polarity
package seg7_pkg;

  localparam int unsigned PWM_PHASES = 16;
  localparam int unsigned BRIGHT_W   = 4;
  localparam int unsigned PHASE_W    = $clog2(PWM_PHASES);

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Used for both com and segment pins: active-low pins invert the logical value.
  function automatic logic drive_level(input logic active, input logic act_low);
    return active ^ act_low;
  endfunction

endpackage

// File: rtl/seg7_scan_timebase.sv
// Scan timebase: sub-cycle prescaler, PWM phase, digit index and blink state.
//   clk, rst    : clock, synchronous active-high reset
//   phase       : PWM phase 0..15 within the current slot
//   digit       : digit index 0..NUM_DIGITS-1 being scanned
//   blink_off   : 1 during the blink-off half-period (changes at frame boundaries)
//   slot_start  : 1 on the first cycle of every slot (phase 0, sub-cycle 0)
module seg7_scan_timebase
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SUB_CYCLES   = 64,
  parameter int unsigned BLINK_FRAMES = 32,
  parameter int unsigned DIG_W        = cnt_width(NUM_DIGITS)
) (
  input  logic               clk,
  input  logic               rst,
  output logic [PHASE_W-1:0] phase,
  output logic [DIG_W-1:0]   digit,
  output logic               blink_off,
  output logic               slot_start
);

  localparam int unsigned SUB_W = cnt_width(SUB_CYCLES);
  localparam int unsigned BLK_W = cnt_width(BLINK_FRAMES);

  localparam logic [SUB_W-1:0]   SUB_LAST   = SUB_W'(SUB_CYCLES - 1);
  localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PWM_PHASES - 1);
  localparam logic [DIG_W-1:0]   DIG_LAST   = DIG_W'(NUM_DIGITS - 1);
  localparam logic [BLK_W-1:0]   BLK_LAST   = BLK_W'(BLINK_FRAMES - 1);

  logic [SUB_W-1:0] sub_cnt;
  logic [BLK_W-1:0] blink_frm;
  logic             sub_wrap;
  logic             phase_wrap;
  logic             frame_wrap;

  assign sub_wrap   = (sub_cnt == SUB_LAST);
  assign phase_wrap = sub_wrap && (phase == PHASE_LAST);
  // Explicit compare against N-1 so non-power-of-2 digit counts never visit unused codes.
  assign frame_wrap = phase_wrap && (digit == DIG_LAST);
  assign slot_start = (sub_cnt == '0) && (phase == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      sub_cnt   <= '0;
      phase     <= '0;
      digit     <= '0;
      blink_frm <= '0;
      blink_off <= 1'b0;
    end else begin
      if (sub_wrap) begin
        sub_cnt <= '0;
        if (phase_wrap) begin
          phase <= '0;
          digit <= frame_wrap ? '0 : digit + 1'b1;
        end else begin
          phase <= phase + 1'b1;
        end
      end else begin
        sub_cnt <= sub_cnt + 1'b1;
      end

      if (frame_wrap) begin
        if (blink_frm == BLK_LAST) begin
          blink_frm <= '0;
          blink_off <= ~blink_off;
        end else begin
          blink_frm <= blink_frm + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/seg7_scan_controller_param.sv
// Time-multiplexed N-digit 7-segment driver with per-digit enable/blink,
// 16-level PWM brightness, one dark phase of dead time per slot and a frame strobe.
//   clk, rst     : clock, synchronous active-high reset
//   seg_data     : packed patterns, digit d = [d*SEG_W +: SEG_W], 1 = lit
//   digit_en     : 0 forces a digit dark
//   blink_en     : 1 makes a digit dark during the blink-off half-period
//   brightness   : 0 = off .. 15 = 15/16 duty
//   com          : one-hot common select (polarity COM_ACT_LOW)
//   seven_seg    : active-digit segments (polarity SEG_ACT_LOW)
//   frame_start  : one-cycle pulse on the first output cycle of digit 0
module seg7_scan_controller_param
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SEG_W        = 7,
  parameter int unsigned SUB_CYCLES   = 64,
  parameter int unsigned BLINK_FRAMES = 32,
  parameter bit          COM_ACT_LOW  = 1'b1,
  parameter bit          SEG_ACT_LOW  = 1'b0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_DIGITS*SEG_W-1:0] seg_data,
  input  logic [NUM_DIGITS-1:0]       digit_en,
  input  logic [NUM_DIGITS-1:0]       blink_en,
  input  logic [BRIGHT_W-1:0]         brightness,
  output logic [NUM_DIGITS-1:0]       com,
  output logic [SEG_W-1:0]            seven_seg,
  output logic                        frame_start
);

  localparam int unsigned DIG_W = cnt_width(NUM_DIGITS);

  logic [PHASE_W-1:0]    phase;
  logic [DIG_W-1:0]      digit;
  logic                  blink_off;
  logic                  slot_start;

  logic [SEG_W-1:0]      pat_sel;
  logic                  en_sel;
  logic                  blink_sel;

  logic [SEG_W-1:0]      pat_l;
  logic                  en_l;
  logic                  blink_l;
  logic [BRIGHT_W-1:0]   bright_l;

  logic                  lit;
  logic [NUM_DIGITS-1:0] com_nxt;
  logic [SEG_W-1:0]      seg_nxt;

  seg7_scan_timebase #(
    .NUM_DIGITS  (NUM_DIGITS),
    .SUB_CYCLES  (SUB_CYCLES),
    .BLINK_FRAMES(BLINK_FRAMES),
    .DIG_W       (DIG_W)
  ) u_timebase (
    .clk       (clk),
    .rst       (rst),
    .phase     (phase),
    .digit     (digit),
    .blink_off (blink_off),
    .slot_start(slot_start)
  );

  // Select the current digit's inputs; compare-based mux avoids out-of-range indexing.
  always_comb begin
    pat_sel   = '0;
    en_sel    = 1'b0;
    blink_sel = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (digit == DIG_W'(i)) begin
        pat_sel   = seg_data[i*SEG_W +: SEG_W];
        en_sel    = digit_en[i];
        blink_sel = blink_en[i];
      end
    end
  end

  // Inputs are frozen for the whole slot so mid-slot changes cannot tear the display.
  // The slot-start cycle itself is phase 0 (always dark), so the latch landing one
  // edge later never affects a lit cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_l    <= '0;
      en_l     <= 1'b0;
      blink_l  <= 1'b0;
      bright_l <= '0;
    end else if (slot_start) begin
      pat_l    <= pat_sel;
      en_l     <= en_sel;
      blink_l  <= blink_sel;
      bright_l <= brightness;
    end
  end

  always_comb begin
    lit = en_l && !(blink_l && blink_off) && (phase != '0) && (phase <= bright_l);
    com_nxt = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      com_nxt[i] = drive_level(lit && (digit == DIG_W'(i)), COM_ACT_LOW);
    end
    seg_nxt = '0;
    for (int unsigned j = 0; j < SEG_W; j++) begin
      seg_nxt[j] = drive_level(lit && pat_l[j], SEG_ACT_LOW);
    end
  end

  // com and segments share one register stage so they always switch together.
  always_ff @(posedge clk) begin
    if (rst) begin
      com         <= {NUM_DIGITS{COM_ACT_LOW}};
      seven_seg   <= {SEG_W{SEG_ACT_LOW}};
      frame_start <= 1'b0;
    end else begin
      com         <= com_nxt;
      seven_seg   <= seg_nxt;
      frame_start <= slot_start && (digit == '0);
    end
  end

endmodule
